// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcodes, compare-bit
// positions and the sequencing FSM state type.
package alu_pkg;
    localparam int DATA_W  = 16;
    localparam int OP_W    = 4;
    localparam int REG_CNT = 8;
    localparam int REG_AW  = $clog2(REG_CNT);

    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;

    localparam int CMP_GT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_LT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;
endpackage

// File: rtl/regfile_8x16.sv
// 8-entry register file: two operand read ports, one debug read port,
// one synchronous write port. r0 is hardwired to zero.
module regfile_8x16
    import alu_pkg::*;
#(
    parameter int DW  = alu_pkg::DATA_W,
    parameter int CNT = alu_pkg::REG_CNT,
    parameter int AW  = $clog2(CNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [DW-1:0] mem_q [CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CNT; i++) mem_q[i] <= '0;
        end else if (we && (wa != '0)) begin
            mem_q[wa] <= wd;
        end
    end

    // r0 is masked on read so a stray write could never leak through.
    assign ra_data  = (ra_addr  == '0) ? '0 : mem_q[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : mem_q[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
endmodule

// File: rtl/alu_issue.sv
// Single-issue operand fetch / execute / writeback sequencer around an
// external combinational ALU. One instruction every three cycles.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int REG_CNT = alu_pkg::REG_CNT,
    parameter int OP_W    = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [2:0]        instr_ra,
    input  logic [2:0]        instr_rb,
    input  logic [2:0]        instr_rd,
    input  logic              instr_imm_en,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_ld,
    input  logic              instr_wb_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [2:0]        alu_comp,
    output logic [2:0]        flags,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_e            state_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q;
    logic [OP_W-1:0]   op_q;
    logic [2:0]        rd_q, flags_q, wb_rd_q;
    logic              ld_q, wb_en_q, wb_valid_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] result_d;

    regfile_8x16 #(.DW(DATA_W), .CNT(REG_CNT), .AW(3)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (instr_ra),
        .ra_data  (rf_a),
        .rb_addr  (instr_rb),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_valid_q),
        .wa       (wb_rd_q),
        .wd       (wb_data_q)
    );

    assign result_d = ld_q ? imm_q : alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            ld_q       <= 1'b0;
            wb_en_q    <= 1'b0;
            flags_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        a_q     <= rf_a;
                        b_q     <= instr_imm_en ? instr_imm : rf_b;
                        op_q    <= instr_op;
                        imm_q   <= instr_imm;
                        rd_q    <= instr_rd;
                        ld_q    <= instr_ld;
                        wb_en_q <= instr_wb_en;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!ld_q) flags_q <= alu_comp;
                    // wb_valid_q doubles as the regfile write strobe, so the
                    // write lands on the edge that ends the WB cycle.
                    if ((wb_en_q || ld_q) && (rd_q != '0)) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= result_d;
                    end
                    state_q <= ST_WB;
                end
                ST_WB:   state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign flags       = flags_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU stand-in
// (SUB = a-b, anything else = a+b; comp is a signed compare of a vs b).
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [2:0]  instr_ra = '0, instr_rb = '0, instr_rd = '0;
    logic        instr_imm_en = 1'b0;
    logic [15:0] instr_imm = '0;
    logic        instr_ld = 1'b0;
    logic        instr_wb_en = 1'b0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic [2:0]  alu_comp, flags, wb_rd;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;
    int wb_cnt = 0;
    logic [15:0] ex_a, ex_b, c_data;
    logic [2:0]  c_rd, c_flags;
    logic        c_wbv;
    int          acc, base;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .instr_rd(instr_rd), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .instr_ld(instr_ld), .instr_wb_en(instr_wb_en),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_comp(alu_comp),
        .flags(flags), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out  = (alu_op == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;
        alu_comp = {$signed(alu_a) > $signed(alu_b), alu_a == alu_b,
                    $signed(alu_a) < $signed(alu_b)};
    end

    always @(negedge clk) if (wb_valid) wb_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Issue one instruction; returns one time step after the edge that ends WB.
    task automatic send(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] rd, input logic imm_en, input logic [15:0] imm,
                        input logic ld, input logic wb_en);
        int n;
        @(negedge clk);
        instr_op = op; instr_ra = ra; instr_rb = rb; instr_rd = rd;
        instr_imm_en = imm_en; instr_imm = imm; instr_ld = ld; instr_wb_en = wb_en;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ex_a = alu_a; ex_b = alu_b;
        @(posedge clk); #1;
        c_wbv = wb_valid; c_rd = wb_rd; c_data = wb_data; c_flags = flags;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'h0, instr_ready}, 32'd1);
        chk("rst_flags", {29'h0, flags}, 32'd0);
        chk("rst_wbv", {31'h0, wb_valid}, 32'd0);
        chk("rst_alu_a", {16'h0, alu_a}, 32'd0);
        dbg("rst_r1", 3'd1, 16'h0);
        @(negedge clk); rst_n = 1'b1;

        send(4'h0, 3'd0, 3'd0, 3'd1, 1'b0, 16'd5, 1'b1, 1'b0);
        chk("ld1_wb", {c_wbv, c_rd, c_data}, {12'h0, 1'b1, 3'd1, 16'd5});
        send(4'h0, 3'd0, 3'd0, 3'd2, 1'b0, 16'd2, 1'b1, 1'b0);
        chk("ld2_wb", {c_wbv, c_rd, c_data}, {12'h0, 1'b1, 3'd2, 16'd2});
        dbg("dbg_r1", 3'd1, 16'd5);

        send(4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("sub_ops", {ex_a, ex_b}, {16'd5, 16'd2});
        chk("sub_flags", {29'h0, c_flags}, 32'b100);
        chk("sub_wb", {c_wbv, c_rd, c_data}, {12'h0, 1'b1, 3'd3, 16'd3});
        dbg("dbg_r3", 3'd3, 16'd3);

        send(4'h0, 3'd0, 3'd0, 3'd4, 1'b0, 16'hFFFA, 1'b1, 1'b0);
        send(4'h0, 3'd0, 3'd0, 3'd5, 1'b0, 16'hFFFB, 1'b1, 1'b0);
        send(4'h0, 3'd0, 3'd0, 3'd6, 1'b0, 16'd4, 1'b1, 1'b0);
        base = wb_cnt;
        send(4'h1, 3'd2, 3'd1, 3'd7, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("cmp_2_5", {29'h0, c_flags}, 32'b001);
        send(4'h1, 3'd1, 3'd1, 3'd7, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("cmp_5_5", {29'h0, c_flags}, 32'b010);
        send(4'h1, 3'd4, 3'd5, 3'd7, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("cmp_m6_m5", {29'h0, c_flags}, 32'b001);
        send(4'h1, 3'd6, 3'd4, 3'd7, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("cmp_4_m6", {29'h0, c_flags}, 32'b100);
        send(4'h1, 3'd1, 3'd0, 3'd7, 1'b1, 16'hFFFA, 1'b0, 1'b0);
        chk("imm_b", {16'h0, ex_b}, 32'h0000FFFA);
        chk("imm_flags", {29'h0, c_flags}, 32'b100);
        chk("cmp_no_wb", wb_cnt, base);
        dbg("r7_untouched", 3'd7, 16'h0);

        base = wb_cnt;
        send(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h1234, 1'b1, 1'b0);
        chk("r0_no_wb", wb_cnt, base);
        dbg("dbg_r0", 3'd0, 16'h0);

        // Hold valid for nine cycles: accepts at cycle 0, 3 and 6 only.
        @(negedge clk);
        instr_op = 4'h0; instr_rd = 3'd7; instr_imm = 16'h0077; instr_ld = 1'b1;
        instr_imm_en = 1'b0; instr_wb_en = 1'b0; instr_valid = 1'b1;
        acc = 0; base = wb_cnt;
        for (int i = 0; i < 9; i++) begin
            if (instr_ready) acc++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("thru_accepts", acc, 32'd3);
        chk("thru_wbs", wb_cnt - base, 32'd3);
        dbg("dbg_r7", 3'd7, 16'h0077);

        // Reset in the middle of EXEC of ld r4=0x00FF.
        base = wb_cnt;
        @(negedge clk);
        instr_rd = 3'd4; instr_imm = 16'h00FF; instr_ld = 1'b1; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {29'h0, flags}, 32'd0);
        chk("mid_rst_alu_a", {16'h0, alu_a}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_ready", {31'h0, instr_ready}, 32'd1);
        chk("mid_rst_no_wb", wb_cnt, base);
        dbg("mid_rst_r4", 3'd4, 16'h0);
        chk("mid_rst_flags2", {29'h0, flags}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
